// File: rtl/stack_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stack_engine: PUSH/POP/PEEK/SETSP stack controller over a data-memory port |
// | Optional top-of-stack cache: STACK_TOS_CACHE_EN      Rev 1.0               |
// +----------------------------------------------------------------------------+
module stack_engine #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(32'h0000_1000),
  parameter int                STACK_DEPTH = 256,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               mem_re,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  sp,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic               ovf_flag,
  output logic               unf_flag
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_SETSP = 2'b11;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX   = DEPTH_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0]  DEPTH_LIMIT = ADDR_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [1:0]        op_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              tos_hit;
  logic [DATA_W-1:0] tos_word;
  logic [ADDR_W-1:0] setsp_v;
  logic [ADDR_W-1:0] setsp_span;
  logic              setsp_ok;

  assign cmd_ready  = (state == IDLE) & reset;
  assign accept     = cmd_valid & cmd_ready;
  assign full       = (depth == DEPTH_MAX);
  assign empty      = (depth == '0);
  assign mem_wdata  = wdata_q;

  assign setsp_v    = cmd_data[ADDR_W-1:0];
  assign setsp_span = STACK_BASE - setsp_v;
  assign setsp_ok   = (setsp_v <= STACK_BASE) && (setsp_span <= DEPTH_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = sp;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUSH:         state_nxt = full ? RESP : MEM;
            OP_POP, OP_PEEK: state_nxt = (empty || tos_hit) ? RESP : MEM;
            default:         state_nxt = RESP;
          endcase
        end
      end
      MEM: begin
        // Request stays up until the memory acknowledges; reset drops it combinationally.
        if (op_q == OP_PUSH) begin
          mem_we   = 1'b1;
          mem_addr = sp - ADDR_W'(1);
        end else begin
          mem_re   = 1'b1;
        end
        if (mem_ack) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp       <= STACK_BASE;
      depth    <= '0;
      op_q     <= OP_PUSH;
      wdata_q  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else if (accept) begin
      op_q    <= cmd_op;
      wdata_q <= cmd_data;
      case (cmd_op)
        OP_PUSH: begin
          if (full) begin
            rsp_err  <= 1'b1;
            ovf_flag <= 1'b1;
          end
        end
        OP_POP, OP_PEEK: begin
          if (empty) begin
            rsp_err  <= 1'b1;
            unf_flag <= 1'b1;
            rsp_data <= '0;
          end else if (tos_hit) begin
            rsp_err  <= 1'b0;
            rsp_data <= tos_word;
            if (cmd_op == OP_POP) begin
              sp    <= sp + ADDR_W'(1);
              depth <= depth - DEPTH_W'(1);
            end
          end
        end
        default: begin
          if (setsp_ok) begin
            sp      <= setsp_v;
            depth   <= DEPTH_W'(setsp_span);
            rsp_err <= 1'b0;
          end else begin
            rsp_err  <= 1'b1;
            ovf_flag <= 1'b1;
          end
        end
      endcase
    end else if ((state == MEM) && mem_ack) begin
      rsp_err <= 1'b0;
      case (op_q)
        OP_PUSH: begin
          sp    <= sp - ADDR_W'(1);
          depth <= depth + DEPTH_W'(1);
        end
        OP_POP: begin
          rsp_data <= mem_rdata;
          sp       <= sp + ADDR_W'(1);
          depth    <= depth - DEPTH_W'(1);
        end
        OP_PEEK: rsp_data <= mem_rdata;
        default: ;
      endcase
    end
  end

`ifdef STACK_TOS_CACHE_EN
  logic [DATA_W-1:0] tos;
  logic              tos_valid;

  // Holds the most recently pushed word until something moves SP past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tos       <= '0;
      tos_valid <= 1'b0;
    end else if ((state == MEM) && mem_ack && (op_q == OP_PUSH)) begin
      tos       <= wdata_q;
      tos_valid <= 1'b1;
    end else if (accept && ((cmd_op == OP_POP) || (cmd_op == OP_SETSP))) begin
      tos_valid <= 1'b0;
    end
  end

  assign tos_hit  = tos_valid;
  assign tos_word = tos;
`else
  assign tos_hit  = 1'b0;
  assign tos_word = '0;
`endif

endmodule
`default_nettype wire
